// File: rtl/async_fifo_pkg.sv
// Shared sizing helpers and defaults for the single-clock async_fifo drop-in.
package async_fifo_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 4;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_w(DEPTH_DEF)-1:0] ptr_t;

endpackage

// File: rtl/async_fifo_mem.sv
// DEPTH x WIDTH storage with a synchronous write port and a registered read port.
module async_fifo_mem import async_fifo_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with full/empty flags; define ASYNC_FIFO_LEVEL_EN to add the level output.
// Handshake: a write is taken on an edge where wr_rq && !full, a read where rd_rq && !empty;
// requests that are blocked are simply dropped, and rdata updates one cycle after an accepted read.
module async_fifo import async_fifo_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             w_clk,
  input  logic             rst,
  input  logic             wr_rq,
  input  logic             rd_rq,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
`ifdef ASYNC_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_ok = wr_rq && !full;
  assign rd_ok = rd_rq && !empty;

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
    end
  end

`ifdef ASYNC_FIFO_LEVEL_EN
  // Modulo-2*DEPTH difference gives 0..DEPTH without any extra state.
  assign level = wptr - rptr;
`endif

  async_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk   (w_clk),
    .rst_n (rst),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo against a queue-based reference model.
module tb_async_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;

  logic             w_clk;
  logic             rst;
  logic             wr_rq;
  logic             rd_rq;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
`ifdef ASYNC_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  async_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .w_clk (w_clk),
    .rst   (rst),
    .wr_rq (wr_rq),
    .rd_rq (rd_rq),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    .level (level)
`endif
  );

  // clock / reset
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_rdata;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
`ifdef ASYNC_FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(level), 32'(exp_q.size()));
`endif
  endtask

  // driver: one clock with the given requests, then model update and checks
  task automatic step(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit wr_ok, rd_ok;
    wr_rq = w;
    rd_rq = r;
    wdata = d;
    wr_ok = w && (exp_q.size() < DEPTH);
    rd_ok = r && (exp_q.size() > 0);
    @(posedge w_clk);
    #1;
    if (rd_ok) exp_rdata = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    wr_rq = 1'b0;
    rd_rq = 1'b0;
    check({tag, ".rdata"}, 32'(rdata), 32'(exp_rdata));
    check_flags(tag);
  endtask

  initial begin
    rst   = 1'b0;
    wr_rq = 1'b0;
    rd_rq = 1'b0;
    wdata = '0;
    exp_rdata = '0;
    #21;
    check("reset.rdata", 32'(rdata), 32'd0);
    check_flags("reset");
    rst = 1'b1;

    // fill, then one blocked write
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, WIDTH'(i));
    check("fill.full_after_8", 32'(full), 32'd1);
    step("fill_blocked", 1'b1, 1'b0, WIDTH'(9));

    // drain in order, then one blocked read
    for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 1'b1, '0);
    check("drain.last", 32'(rdata), 32'd8);
    step("drain_blocked", 1'b0, 1'b1, '0);
    check("drain_blocked.hold", 32'(rdata), 32'd8);

    // concurrent push/pop at occupancy 3
    for (int i = 0; i < 3; i++) step("conc_pre", 1'b1, 1'b0, WIDTH'(10 + i));
    for (int i = 0; i < 5; i++) step("conc", 1'b1, 1'b1, WIDTH'(i + 1));
    check("conc.occupancy", 32'(exp_q.size()), 32'd3);
    check("conc.not_empty", 32'(empty), 32'd0);

    // randomized traffic across many pointer wraps
    begin
      int writes = 0;
      int guard = 0;
      while (writes < 150 && guard < 2000) begin
        logic w, r;
        w = ($urandom_range(0, 99) < 55);
        r = ($urandom_range(0, 99) < 50);
        if (w && exp_q.size() < DEPTH) writes++;
        step("wrap", w, r, WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
        guard++;
      end
      check("wrap.writes_done", 32'(writes), 32'd150);
      while (exp_q.size() > 0 && guard < 2200) begin
        step("wrap_drain", 1'b0, 1'b1, '0);
        guard++;
      end
    end

    // asynchronous reset at occupancy 5, asserted between edges
    for (int i = 0; i < 5; i++) step("mid_pre", 1'b1, 1'b0, WIDTH'(3 + i));
    check("mid_pre.occupancy", 32'(exp_q.size()), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_rdata = '0;
    check("mid_reset.empty", 32'(empty), 32'd1);
    check("mid_reset.full", 32'(full), 32'd0);
    check("mid_reset.rdata", 32'(rdata), 32'd0);
    #1;
    rst = 1'b1;
    step("post_reset_wr", 1'b1, 1'b0, 4'hA);
    step("post_reset_rd", 1'b0, 1'b1, '0);
    check("post_reset.data", 32'(rdata), 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
